send_out: RTL and testbench
===========================

# send_out

Transmit side of the key-entry packet path. Drains the four 6-entry packet buffers filled by the receive block, which expose each buffer as a packed 18-bit vector. Arbitrates round-robin among the buffer heads, pulses a pop back to the writer, and shifts each packet out as a 5-bit serial frame on a single line. Also provides a transmitted-packet count and the last frame for display.

## Interface
Parameters:
- BIT_CYCLES, 4, clock cycles per serial bit; legal range ≥2.
- GAP_CYCLES, 2, idle-low cycles after each frame; legal range ≥1.
- CNT_W, 8, width of `sent_count`.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  enable; 0 means no new frame is started.
- buffer1_i..buffer4_i  in  18 each  packed queue; entry k = bits [3k+2:3k] = {payload[1:0], valid}; entry 0 is the head.
- pop  out  4  one-hot, one-cycle pulse; bit q consumes the head of buffer q+1.
- tx_bit  out  1  serial line; idle 0.
- tx_busy  out  1  high from the cycle after selection until GAP ends.
- tx_frame  out  4  last loaded frame {id[1:0], payload[1:0]}.
- sent_count  out  CNT_W  frames completed, modulo 2^CNT_W.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If start=1 and any head valid bit is 1, select q = first valid buffer scanning rr, rr+1, … mod 4.
  - At that edge, register pop=1<<q, latch tx_frame={q[1:0], payload}, and load the shift register with {1, q[1], q[0], p[1], p[0]}.
  - Update rr ← q+1 mod 4 and go to SHIFT.
- SHIFT:
  - 5 bits, MSB first, each held BIT_CYCLES cycles.
  - The first bit is the start bit (1).
  - At the edge ending the last bit: sent_count+1 (wraps), go to GAP.
- GAP: tx_bit=0 for GAP_CYCLES cycles, then IDLE.
- Head contents are sampled only at selection. Later changes to the head, including invalidation, do not affect a frame in flight.
- start=0 during SHIFT or GAP: the current frame completes normally, then the block stays in IDLE.
- No valid heads: remain in IDLE; rr is unchanged.
- Only entry 0 of each buffer is read; entries 1–5 are ignored.

## Timing
- Reset values: pop=0, tx_bit=0, tx_busy=0, tx_frame=0, sent_count=0, rr=0, state IDLE.
- Reset mid-frame clears everything immediately. The frame is not counted, and no pop is reissued.
- Selection latency: a valid head with start=1 in IDLE at cycle N gives pop high during cycle N+1 only, and tx_bit=1 (start bit) from cycle N+1.
- Frame occupies cycles N+1 … N+5·BIT_CYCLES.
- GAP covers the next GAP_CYCLES cycles. The earliest next selection is in the following cycle.
- Minimum frame period: 5·BIT_CYCLES + GAP_CYCLES + 1 cycles.
- The writer shifts its buffer on the edge after it sees pop. Because the frame outlasts that one cycle, a stale head is never reselected.
- sent_count updates on the same edge that leaves SHIFT.
- tx_busy falls on the edge that enters IDLE.

## Structure
- Shared package contents:
  - ENTRY_W=3, DEPTH=6, FRAME_BITS=5, ID_W=2.
  - Entry field positions (valid bit 0, payload bits 2:1).
  - Buffer id encoding 0–3 ↔ buffer1–4.
  - FSM state enum.
- Natural sub-module: `rr_pick4`. It is combinational: takes a 4-bit valid vector and the rr pointer, and returns any_valid and the selected index.
- Bit timing uses a bit-cycle counter and a bit index counter in the top level.

## Test plan
- Reset: assert rst_n=0 mid-simulation → all outputs 0. Release with all heads invalid → no pop for 100 cycles.
- Single packet, BIT_CYCLES=4:
  - Stimulus: buffer3_i[2:0]=3'b101 (payload 10), start=1.
  - Expected: pop=4'b0100 for exactly 1 cycle and tx_frame=4'b1010.
  - tx_bit sequence 1,1,0,1,0, each held 4 cycles, then 0 for the GAP.
  - sent_count=1.
- Round-robin: all four heads valid with rr=0, and the bench model shifts the buffers on pop → frame ids 00,01,10,11 in order. Then buffer1 only valid → next id 00.
- Fairness: buffer1 and buffer4 continuously valid → ids alternate 00,11,00,11.
- start control:
  - start=0 with valid heads → no pop.
  - start dropped during bit 2 → frame completes and is counted, with no further pop.
- Reset during SHIFT bit 3 → tx_bit=0 and tx_busy=0 immediately, sent_count stays 0, and rr returns to 0. With CNT_W=2, five frames → sent_count=1.

Source files
------------

// File: rtl/send_out_pkg.sv
// send_out_pkg: shared constants, entry layout, buffer ids and FSM
// states for the key-entry transmit path.
package send_out_pkg;

  localparam int ENTRY_W    = 3;
  localparam int DEPTH      = 6;
  localparam int FRAME_BITS = 5;
  localparam int ID_W       = 2;
  localparam int PAY_W      = 2;
  localparam int BUF_W      = ENTRY_W * DEPTH;

  localparam int VALID_BIT = 0;
  localparam int PAY_LO    = 1;
  localparam int PAY_HI    = 2;

  localparam logic [ID_W-1:0] ID_BUF1 = 2'd0;
  localparam logic [ID_W-1:0] ID_BUF2 = 2'd1;
  localparam logic [ID_W-1:0] ID_BUF3 = 2'd2;
  localparam logic [ID_W-1:0] ID_BUF4 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [FRAME_BITS-1:0] make_frame(
    input logic [ID_W-1:0]  id,
    input logic [PAY_W-1:0] pay
  );
    return {1'b1, id, pay};
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick over four requesters.
// Ports: valid/rr in; any_valid and sel (first valid from rr) out.
module rr_pick4
  import send_out_pkg::*;
(
  input  logic [3:0]      valid,
  input  logic [ID_W-1:0] rr,
  output logic            any_valid,
  output logic [ID_W-1:0] sel
);

  logic [ID_W-1:0] idx;

  // Scan from farthest to nearest so the lowest offset from rr wins.
  always_comb begin
    any_valid = 1'b0;
    sel       = rr;
    idx       = rr;
    for (int i = 3; i >= 0; i--) begin
      idx = rr + ID_W'(i);
      if (valid[idx]) begin
        any_valid = 1'b1;
        sel       = idx;
      end
    end
  end

endmodule

// File: rtl/send_out.sv
// send_out: round-robin drain of four packet buffer heads into 5-bit
// serial frames. Ports: clk, rst_n, start, buffer1_i..buffer4_i in;
// pop, tx_bit, tx_busy, tx_frame, sent_count out.
module send_out
  import send_out_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BUF_W-1:0] buffer1_i,
  input  logic [BUF_W-1:0] buffer2_i,
  input  logic [BUF_W-1:0] buffer3_i,
  input  logic [BUF_W-1:0] buffer4_i,
  output logic [3:0]       pop,
  output logic             tx_bit,
  output logic             tx_busy,
  output logic [3:0]       tx_frame,
  output logic [CNT_W-1:0] sent_count
);

  localparam int BC_W = $clog2(BIT_CYCLES);
  localparam int GC_W = $clog2(GAP_CYCLES + 1);
  localparam int BI_W = $clog2(FRAME_BITS);

  logic [ENTRY_W-1:0]    head [4];
  logic [3:0]            head_valid;
  logic                  any_valid;
  logic [ID_W-1:0]       sel;
  logic [ID_W-1:0]       rr;
  state_t                state;
  state_t                state_nxt;
  logic [BC_W-1:0]       bit_cnt;
  logic [BI_W-1:0]       bit_idx;
  logic [GC_W-1:0]       gap_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  launch;
  logic                  bit_end;
  logic                  frame_end;
  logic                  unused_entries;

  // Only the head entry of each buffer is ever read.
  assign head[ID_BUF1] = buffer1_i[ENTRY_W-1:0];
  assign head[ID_BUF2] = buffer2_i[ENTRY_W-1:0];
  assign head[ID_BUF3] = buffer3_i[ENTRY_W-1:0];
  assign head[ID_BUF4] = buffer4_i[ENTRY_W-1:0];

  assign unused_entries = ^{buffer1_i[BUF_W-1:ENTRY_W],
                            buffer2_i[BUF_W-1:ENTRY_W],
                            buffer3_i[BUF_W-1:ENTRY_W],
                            buffer4_i[BUF_W-1:ENTRY_W]};

  always_comb begin
    head_valid = '0;
    for (int i = 0; i < 4; i++) begin
      head_valid[i] = head[i][VALID_BIT];
    end
  end

  rr_pick4 u_pick (
    .valid     (head_valid),
    .rr        (rr),
    .any_valid (any_valid),
    .sel       (sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    frame_end = 1'b0;
    bit_end   = (bit_cnt == BC_W'(BIT_CYCLES - 1));
    unique case (state)
      IDLE: begin
        if (start && any_valid) begin
          launch    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_end && bit_idx == BI_W'(FRAME_BITS - 1)) begin
          frame_end = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GC_W'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop        <= '0;
      tx_frame   <= '0;
      sent_count <= '0;
      rr         <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
    end else begin
      pop <= '0;
      if (launch) begin
        pop      <= 4'b0001 << sel;
        tx_frame <= {sel, head[sel][PAY_HI:PAY_LO]};
        shreg    <= make_frame(sel, head[sel][PAY_HI:PAY_LO]);
        rr       <= sel + ID_W'(1);
        bit_cnt  <= '0;
        bit_idx  <= '0;
      end
      if (state == SHIFT) begin
        if (bit_end) begin
          bit_cnt <= '0;
          bit_idx <= bit_idx + BI_W'(1);
          shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
        end else begin
          bit_cnt <= bit_cnt + BC_W'(1);
        end
      end
      if (frame_end) begin
        sent_count <= sent_count + CNT_W'(1);
        gap_cnt    <= '0;
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt + GC_W'(1);
      end
    end
  end

  assign tx_bit  = (state == SHIFT) & shreg[FRAME_BITS-1];
  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_send_out.sv
// tb_send_out: directed scoreboard bench for send_out with a writer
// model that shifts each buffer on its pop pulse.
module tb_send_out;

  localparam int BC  = 4;
  localparam int GC  = 2;
  localparam int CW  = 2;

  typedef struct {
    logic [3:0] pop;
    logic [3:0] frame;
    logic [4:0] bits;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [17:0]   bufs [4];
  logic [17:0]   ld_buf [4];
  logic          ld_tog = 1'b0;
  logic          ld_ack = 1'b0;
  logic [3:0]    pop;
  logic          tx_bit;
  logic          tx_busy;
  logic [3:0]    tx_frame;
  logic [CW-1:0] sent_count;

  exp_t          sb [$];
  int            vectors = 0;
  int            miscompares = 0;
  logic          mon_busy = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  send_out #(
    .BIT_CYCLES (BC),
    .GAP_CYCLES (GC),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .buffer1_i  (bufs[0]),
    .buffer2_i  (bufs[1]),
    .buffer3_i  (bufs[2]),
    .buffer4_i  (bufs[3]),
    .pop        (pop),
    .tx_bit     (tx_bit),
    .tx_busy    (tx_busy),
    .tx_frame   (tx_frame),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) begin
      bufs[i]   = '0;
      ld_buf[i] = '0;
    end
  end

  // Writer model: a load request replaces all buffers, else pop shifts.
  always @(posedge clk) begin
    if (ld_tog != ld_ack) begin
      for (int i = 0; i < 4; i++) bufs[i] <= ld_buf[i];
      ld_ack <= ld_tog;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pop[i]) bufs[i] <= {3'b000, bufs[i][17:3]};
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  task automatic push(input logic [3:0] p, input logic [3:0] f,
                      input logic [4:0] b);
    exp_t e;
    e.pop = p;
    e.frame = f;
    e.bits = b;
    sb.push_back(e);
  endtask

  task automatic load(input logic [17:0] b1, input logic [17:0] b2,
                      input logic [17:0] b3, input logic [17:0] b4);
    ld_buf[0] = b1;
    ld_buf[1] = b2;
    ld_buf[2] = b3;
    ld_buf[3] = b4;
    ld_tog = ~ld_tog;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !mon_busy && !tx_busy && pop == 4'b0)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        timeout(name);
        sb.delete();
        break;
      end
    end
  endtask

  task automatic wait_pop(input string name);
    int n;
    n = 0;
    while (pop == 4'b0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        timeout(name);
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pop"}, {4'b0, pop}, 8'd0);
    chk({tag, "_tx_bit"}, {7'b0, tx_bit}, 8'd0);
    chk({tag, "_tx_busy"}, {7'b0, tx_busy}, 8'd0);
    chk({tag, "_tx_frame"}, {4'b0, tx_frame}, 8'd0);
    chk({tag, "_sent_count"}, {6'b0, sent_count}, 8'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every pop pulse and follows the
  // frame through its bits, gap and return to idle.
  initial begin
    exp_t e;
    logic aborted;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt = '0;
      end else if (pop != 4'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", {4'b0, pop}, 8'd0);
        end else begin
          e = sb.pop_front();
          mon_busy = 1'b1;
          aborted = 1'b0;
          chk("pop", {4'b0, pop}, {4'b0, e.pop});
          chk("tx_frame", {4'b0, tx_frame}, {4'b0, e.frame});
          for (int k = 0; k < 5 * BC; k++) begin
            if (k > 0) begin
              @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
                break;
              end
              chk("pop_one_cycle", {4'b0, pop}, 8'd0);
            end
            chk("tx_bit", {7'b0, tx_bit}, {7'b0, e.bits[4 - k / BC]});
            chk("tx_busy_frame", {7'b0, tx_busy}, 8'd1);
          end
          if (!aborted) begin
            exp_cnt = exp_cnt + CW'(1);
            for (int g = 0; g < GC; g++) begin
              @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
                break;
              end
              chk("gap_tx_bit", {7'b0, tx_bit}, 8'd0);
              chk("gap_tx_busy", {7'b0, tx_busy}, 8'd1);
              if (g == 0) begin
                chk("sent_count", {6'b0, sent_count}, {6'b0, exp_cnt});
              end
            end
          end
          if (!aborted) begin
            @(negedge clk);
            if (rst_n) chk("busy_fall", {7'b0, tx_busy}, 8'd0);
            else aborted = 1'b1;
          end
          if (aborted) exp_cnt = '0;
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_busy", {7'b0, tx_busy}, 8'd0);

    // Single packet from buffer3, payload 10.
    push(4'b0100, 4'b1010, 5'b11010);
    load(18'd0, 18'd0, {15'd0, 3'b101}, 18'd0);
    wait_drain("single");
    chk("single_count", {6'b0, sent_count}, 8'd1);

    // Round-robin over all four, buffer1 holding a second entry.
    do_reset("reset_mid");
    push(4'b0001, 4'b0001, 5'b10001);
    push(4'b0010, 4'b0111, 5'b10111);
    push(4'b0100, 4'b1000, 5'b11000);
    push(4'b1000, 4'b1110, 5'b11110);
    push(4'b0001, 4'b0010, 5'b10010);
    load({12'd0, 3'b101, 3'b011}, {15'd0, 3'b111},
         {15'd0, 3'b001}, {15'd0, 3'b101});
    wait_drain("round_robin");
    chk("rr_count_wrap", {6'b0, sent_count}, 8'd1);

    // Fairness between buffer1 and buffer4.
    do_reset("reset_fair");
    push(4'b0001, 4'b0010, 5'b10010);
    push(4'b1000, 4'b1111, 5'b11111);
    push(4'b0001, 4'b0001, 5'b10001);
    push(4'b1000, 4'b1100, 5'b11100);
    load({12'd0, 3'b011, 3'b101}, 18'd0, 18'd0, {12'd0, 3'b001, 3'b111});
    wait_drain("fairness");
    chk("fair_count", {6'b0, sent_count}, 8'd0);

    // start=0 holds off, then dropped mid-frame.
    start = 1'b0;
    load(18'd0, {12'd0, 3'b011, 3'b111}, 18'd0, 18'd0);
    repeat (60) @(negedge clk);
    chk("start0_busy", {7'b0, tx_busy}, 8'd0);
    push(4'b0010, 4'b0111, 5'b10111);
    start = 1'b1;
    wait_pop("drop_pop");
    repeat (BC + 1) @(negedge clk);
    start = 1'b0;
    wait_drain("drop");
    repeat (60) @(negedge clk);
    chk("drop_count", {6'b0, sent_count}, 8'd1);
    chk("drop_head_kept", {7'b0, bufs[1][0]}, 8'd1);

    // Reset during the third bit of the next frame.
    push(4'b0010, 4'b0101, 5'b10101);
    start = 1'b1;
    wait_pop("rst_pop");
    repeat (2 * BC + 1) @(negedge clk);
    chk("pre_rst_tx_bit", {7'b0, tx_bit}, 8'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1 check_zero("rst_shift");
    load({15'd0, 3'b111}, 18'd0, {15'd0, 3'b001}, 18'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    push(4'b0001, 4'b0011, 5'b10011);
    push(4'b0100, 4'b1000, 5'b11000);
    start = 1'b1;
    wait_drain("after_rst");
    chk("final_count", {6'b0, sent_count}, 8'd2);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
